// File: rtl/piso_shift_reg_pkg.sv
// Shared FSM state encodings and bit-order constants for the parametrised PISO.
package piso_shift_reg_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_counter.sv
// Serial bit counter: clears on word load, counts shifted data bits, saturates at WIDTH.
module piso_bit_counter
    import piso_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(WIDTH))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // tc marks the final data bit of the word currently on the line
    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register with valid/ready load and back-to-back streaming.
// Optional trailing parity bit enabled by defining PISO_PARITY_EN.
//   state     | meaning
//   ST_IDLE   | no word in flight, s_out = IDLE_VAL, ready for a load
//   ST_SHIFT  | data bits on s_out, advance one per shift_en
//   ST_PARITY | parity bit on s_out (PISO_PARITY_EN only)
module piso_shift_reg
    import piso_shift_reg_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic FILL_VAL   = 1'b0,
    parameter logic IDLE_VAL   = 1'b1,
    parameter logic ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic             lsb_first,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shf;
    logic             dir;
    logic             tc;
    logic             par_bit;
    logic             accept;
    logic             shift_data;

    assign s_valid    = (state != ST_IDLE);
    assign busy       = s_valid;
    assign ld_ready   = (state == ST_IDLE) || (s_last && shift_en);
    assign accept     = ld_valid && ld_ready;
    assign shift_data = (state == ST_SHIFT) && shift_en;

`ifdef PISO_PARITY_EN
    assign s_last = (state == ST_PARITY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= (^d_in) ^ ODD_PARITY;
        end
    end
`else
    assign s_last = (state == ST_SHIFT) && tc;
    // ST_PARITY is unreachable in this build; the mux leg is a constant tie-off
    assign par_bit = ODD_PARITY;
`endif

    generate
        if (WIDTH == 1) begin : g_shift_one
            assign sreg_shf = FILL_VAL;
        end else begin : g_shift_multi
            assign sreg_shf = (dir == ORDER_MSB_FIRST) ? {sreg[WIDTH-2:0], FILL_VAL}
                                                       : {FILL_VAL, sreg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        s_out = IDLE_VAL;
        case (state)
            ST_SHIFT:  s_out = (dir == ORDER_LSB_FIRST) ? sreg[0] : sreg[WIDTH-1];
            ST_PARITY: s_out = par_bit;
            default:   s_out = IDLE_VAL;
        endcase
    end

    // An accept always starts a fresh word, including the reload on a final edge
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = ST_SHIFT;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (shift_en && tc) begin
`ifdef PISO_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_IDLE;
`endif
                    end
                end
                ST_PARITY: begin
                    if (shift_en) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
            dir   <= ORDER_MSB_FIRST;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sreg <= d_in;
                dir  <= lsb_first;
            end else if (shift_data) begin
                sreg <= sreg_shf;
            end
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (shift_data),
        .tc    (tc)
    );

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg (WIDTH=4): directed scenarios plus random traffic
// against a word-level serial model. Honours PISO_PARITY_EN when defined.
module tb_piso_shift_reg;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
    localparam logic [31:0] T2 = 32'b10111;
    localparam logic [31:0] T3 = 32'b11011;
    localparam logic [31:0] T4 = 32'b111_000_000_111_000;
    localparam logic [31:0] T5 = 32'b00110_11000;
`else
    localparam int NB = W;
    localparam logic [31:0] T2 = 32'b1011;
    localparam logic [31:0] T3 = 32'b1101;
    localparam logic [31:0] T4 = 32'b111_000_000_111;
    localparam logic [31:0] T5 = 32'b0011_1100;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         shift_en = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_ready;
    logic [W-1:0] d_in = '0;
    logic         lsb_first = 1'b0;
    logic         s_out;
    logic         s_valid;
    logic         s_last;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic        m_active = 1'b0;
    logic        m_bits [0:NB-1];
    int          m_pos = 0;

    logic [31:0] rec = '0;
    int          rec_n = 0;
    int          rec_last = 0;
    int          run = 0;
    int          maxrun = 0;

    always #5 clk = ~clk;

    piso_shift_reg #(
        .WIDTH      (W),
        .FILL_VAL   (1'b0),
        .IDLE_VAL   (1'b1),
        .ODD_PARITY (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .d_in      (d_in),
        .lsb_first (lsb_first),
        .s_out     (s_out),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: outputs settle after the negedge input update, model advances to the next edge
    always @(negedge clk) begin
        logic e_out, e_last, e_ready, acc;
        #2;
        if (reset) begin
            m_active = 1'b0;
            chk("rst_valid", s_valid, 1'b0);
            chk("rst_out", s_out, 1'b1);
            chk("rst_last", s_last, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end else begin
            e_out   = m_active ? m_bits[m_pos] : 1'b1;
            e_last  = m_active && (m_pos == NB - 1);
            e_ready = !m_active || (e_last && shift_en);
            chk("s_valid", s_valid, m_active);
            chk("s_out", s_out, e_out);
            chk("s_last", s_last, e_last);
            chk("ld_ready", ld_ready, e_ready);
            chk("busy", busy, m_active);
            acc = ld_valid && e_ready;
            if (m_active && shift_en) begin
                m_pos++;
                if (m_pos == NB) m_active = 1'b0;
            end
            if (acc) begin
                for (int i = 0; i < W; i++)
                    m_bits[i] = lsb_first ? d_in[i] : d_in[W-1-i];
`ifdef PISO_PARITY_EN
                m_bits[W] = ^d_in;
`endif
                m_pos = 0;
                m_active = 1'b1;
            end
        end
        if (s_valid) begin
            rec = {rec[30:0], s_out};
            rec_n++;
            if (s_last) rec_last++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic cyc(input logic sh, input logic lv, input logic [W-1:0] d, input logic lf);
        @(negedge clk);
        shift_en  = sh;
        ld_valid  = lv;
        d_in      = d;
        lsb_first = lf;
    endtask

    task automatic clr_rec();
        rec = '0;
        rec_n = 0;
        rec_last = 0;
        run = 0;
        maxrun = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cyc(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        #3;
        chk("post_rst_ready", ld_ready, 1'b1);

        // MSB first, continuous shifting
        cyc(1'b1, 1'b1, 4'b1011, 1'b0);
        clr_rec();
        repeat (NB) cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        #3;
        chk_v("t2_bits", rec, T2);
        chk_v("t2_count", 32'(rec_n), 32'(NB));
        chk_v("t2_last", 32'(rec_last), 32'd1);

        // LSB first; lsb_first toggles mid-word
        cyc(1'b1, 1'b1, 4'b1011, 1'b1);
        clr_rec();
        for (int i = 0; i < NB; i++) cyc(1'b1, 1'b0, '0, 1'(i));
        cyc(1'b0, 1'b0, '0, 1'b0);
        #3;
        chk_v("t3_bits", rec, T3);

        // shift_en every third cycle, spurious ld_valid before the final bit
        cyc(1'b0, 1'b1, 4'b1001, 1'b0);
        clr_rec();
        for (int i = 0; i < 3 * NB; i++) cyc((i % 3) == 2, i < 3 * (NB - 1), 4'h5, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        #3;
        chk_v("t4_bits", rec, T4);
        chk_v("t4_count", 32'(rec_n), 32'(3 * NB));
        chk_v("t4_last", 32'(rec_last), 32'd3);

        // back-to-back streaming with ld_valid held
        cyc(1'b1, 1'b1, 4'h3, 1'b0);
        clr_rec();
        for (int i = 0; i < NB; i++) cyc(1'b1, 1'b1, 4'hC, 1'b0);
        for (int i = 0; i < NB; i++) cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        #3;
        chk_v("t5_bits", rec, T5);
        chk_v("t5_run", 32'(maxrun), 32'(2 * NB));

`ifdef PISO_PARITY_EN
        cyc(1'b1, 1'b1, 4'b0111, 1'b0);
        clr_rec();
        repeat (NB) cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        #3;
        chk_v("t6_bits", rec, 32'b01111);
        chk_v("t6_last", 32'(rec_last), 32'd1);
`endif

        // async reset in the middle of 4'hA
        cyc(1'b1, 1'b1, 4'hA, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, '0, 1'b0);
        #4 reset = 1'b1;
        #1;
        chk("t1_async_valid", s_valid, 1'b0);
        chk("t1_async_out", s_out, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        #3;
        chk("t1_ready", ld_ready, 1'b1);
        chk("t1_valid", s_valid, 1'b0);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            reset = ($urandom_range(0, 99) == 0);
        end
        cyc(1'b1, 1'b0, '0, 1'b0);
        reset = 1'b0;
        repeat (NB + 2) cyc(1'b1, 1'b0, '0, 1'b0);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
